// File: rtl/unpool_pkg.sv
// Shared types and helpers for the 2x2 nearest-neighbour upsampler.
// Lane width, control states and the output-to-input lane mapping.
package unpool_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    // Output lanes 2k and 2k+1 both come from input lane k.
    function automatic int unsigned src_lane(input int unsigned out_lane);
        return out_lane >> 1;
    endfunction

endpackage

// File: rtl/unpooling_2x2_if.sv
// Stream bundle between the upsampler and its neighbours.
// master drives the pooled input and consumes the upsampled output.
interface unpooling_2x2_if
    import unpool_pkg::*;
#(
    parameter int POX    = 4,
    parameter int DATA_W = unpool_pkg::DATA_W
);

    logic [POX/2*DATA_W-1:0] in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic [POX*DATA_W-1:0]   out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;
    logic                    overflow;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, overflow
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, overflow
    );

endinterface

// File: rtl/row_buffer.sv
// One-row store: synchronous write port, asynchronous read port.
// Contents are not reset; only written entries are ever read back.
module row_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/unpooling_2x2.sv
// 2x2 nearest-neighbour upsampler: duplicates lanes horizontally and
// replays each buffered row once more for the vertical copy.
module unpooling_2x2
    import unpool_pkg::*;
#(
    parameter int POX           = 4,
    parameter int ROW_BEATS_MAX = 16,
    parameter int DATA_W        = unpool_pkg::DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    unpooling_2x2_if.slave  bus
);

    localparam int IN_W  = POX/2*DATA_W;
    localparam int OUT_W = POX*DATA_W;
    localparam int AW    = $clog2(ROW_BEATS_MAX);

    localparam logic [AW-1:0] LAST_IDX = AW'(ROW_BEATS_MAX-1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);

    state_t        state;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW:0]   row_len;

    logic          load_ok;
    logic          accept;
    logic          wr_last;
    logic          row_end;
    logic          rep_load;
    logic          rd_last;
    logic [IN_W-1:0]  rd_data;
    logic [IN_W-1:0]  src;
    logic [OUT_W-1:0] dup;

    row_buffer #(
        .DEPTH (ROW_BEATS_MAX),
        .WIDTH (IN_W),
        .AW    (AW)
    ) u_row_buffer (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_idx),
        .wdata (bus.in_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    assign load_ok     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == FILL) && load_ok;
    assign accept      = bus.in_valid && bus.in_ready;
    assign wr_last     = (wr_idx == LAST_IDX);
    assign row_end     = bus.in_last || wr_last;
    assign rd_last     = ({1'b0, rd_idx} == (row_len - LEN_ONE));

    // The first replay beat waits for the register to empty, giving
    // one turnaround bubble between the two copies of a row.
    assign rep_load = (state == REPLAY) &&
                      ((rd_idx == '0) ? !bus.out_valid : load_ok);

    assign src = (state == REPLAY) ? rd_data : bus.in_data;

    for (genvar i = 0; i < POX; i++) begin : g_dup
        assign dup[i*DATA_W +: DATA_W] =
            src[src_lane(i)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FILL;
            wr_idx        <= '0;
            rd_idx        <= '0;
            row_len       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
            bus.overflow  <= 1'b0;
        end else if (accept) begin
            bus.out_data  <= dup;
            bus.out_valid <= 1'b1;
            bus.out_last  <= row_end;
            if (row_end) begin
                row_len <= {1'b0, wr_idx} + LEN_ONE;
                wr_idx  <= '0;
                rd_idx  <= '0;
                state   <= REPLAY;
                if (!bus.in_last) bus.overflow <= 1'b1;
            end else begin
                wr_idx <= wr_idx + IDX_ONE;
            end
        end else if (rep_load) begin
            bus.out_data  <= dup;
            bus.out_valid <= 1'b1;
            bus.out_last  <= rd_last;
            if (rd_last) begin
                rd_idx <= '0;
                state  <= FILL;
            end else begin
                rd_idx <= rd_idx + IDX_ONE;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/unpooling_2x2.md
Name: unpooling_2x2

Overview:
- 2x2 nearest-neighbour upsampler (max-unpool inverse) in the decoder/upsample path.
- Consumes pooled rows of POX/2 lanes of 16-bit values and emits POX-lane rows. Each input lane is duplicated horizontally, and each full row is emitted twice (vertical duplication).
- Stores one row in an internal row buffer and replays it for the second copy.

Parameters:
- POX, 4, output lanes per beat; input carries POX/2 lanes; must be even and >= 2.
- ROW_BEATS_MAX, 16, maximum beats per row held in the row buffer.
- DATA_W, 16, bits per lane.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  POX/2*DATA_W  pooled lanes; lane k occupies bits [(k+1)*16-1:k*16].
- in_valid  input  1  in_data valid.
- in_last  input  1  marks final beat of a row.
- in_ready  output  1  block accepts a beat when in_valid && in_ready.
- out_data  output  POX*DATA_W  upsampled lanes.
- out_valid  output  1  out_data valid.
- out_last  output  1  final beat of each emitted row copy.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- overflow  output  1  sticky: a row exceeded ROW_BEATS_MAX beats.

Behaviour:
- Reset (async, rst_n low): state=FILL; wr_idx=0; rd_idx=0; row_len=0; out_valid=0; out_last=0; out_data=0; overflow=0. Row buffer contents are don't-care.
- Output register: single stage. "load_ok" = !out_valid || out_ready. Whenever a beat is loaded, out_valid=1. If out_ready is high and nothing is loaded, out_valid=0 next cycle.
- Lane mapping: out lane 2k and out lane 2k+1 = in lane k, for k in 0..POX/2-1. No arithmetic; values pass bit-exact.
- FILL state:
  - in_ready = load_ok.
  - On accept: buffer[wr_idx] <= in_data; the output register loads the duplicated beat; out_last <= in_last || (wr_idx==ROW_BEATS_MAX-1); wr_idx++.
  - On an accepted last beat (in_last, or forced at wr_idx==ROW_BEATS_MAX-1): row_len <= wr_idx+1; wr_idx <= 0; rd_idx <= 0; next state REPLAY.
  - A forced last without in_last sets overflow (sticky until reset). Subsequent input beats start a new row.
  - Latency from input accept to out_valid: 1 cycle.
- REPLAY state:
  - in_ready = 0.
  - Each cycle with load_ok: the output register loads the duplicated buffer[rd_idx]; out_last <= (rd_idx==row_len-1); rd_idx++.
  - After loading rd_idx==row_len-1: next state FILL. The earliest new input accept is the following cycle.
  - The first replay beat loads the cycle after the last first-copy beat leaves the register. If out_ready is held high, there are no bubbles except the one-cycle FILL/REPLAY turnaround.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable.
- Single-beat row (in_last on first beat): row_len=1; output is two beats, each with out_last=1.
- Reset mid-row or mid-replay: the partial row is discarded and no further output is produced.
- Throughput: per input row of N beats, 2N output beats. Input is stalled for N+1 cycles minimum per row.

Decomposition:
- Shared package unpool_pkg: DATA_W constant, state enum {FILL, REPLAY}, lane-duplication function.
- Sub-module row_buffer: ROW_BEATS_MAX x (POX/2*DATA_W) register array with one write port and one asynchronous read port, indexed by $clog2(ROW_BEATS_MAX) bits.
- Control FSM, counters and output register stay in unpooling_2x2.

Test Plan:
- POX=4, one row of 2 beats {0x0001,0x0002}, {0x0003,0x0004}, in_last on beat 2, out_ready=1 -> 4 out beats {1,1,2,2},{3,3,4,4},{1,1,2,2},{3,3,4,4}; out_last on beats 2 and 4; in_ready low during replay.
- Single-beat row {0xFFFF,0x8000} -> two beats {0xFFFF,0xFFFF,0x8000,0x8000}, each with out_last=1; overflow=0.
- Random out_ready toggling (50%) over 8 rows of 3 beats -> 48 out beats matching the golden model; data stable while stalled; no drops or duplicates beyond the 2x repeat.
- ROW_BEATS_MAX=4, 6 beats without in_last -> beat 4 forces out_last and replay of 4 beats; overflow=1 stays high; beats 5-6 form the next row.
- Assert rst_n low during REPLAY after 1 replay beat -> out_valid=0 immediately (async). After release, a new row of 1 beat yields exactly 2 out beats.
- Back-to-back rows, in_valid constantly high -> in_ready low for row_len+1 cycles per row; ordering row A, A, B, B preserved.
